// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: CPU (port 0) has priority, the secondary
// master (port 1) is aged and wins after MAX_WAIT consecutive denials.
// Also keeps a saturating count of cycles in which both ports requested.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       gnt0;
  logic       gnt1;

  // Grant decision; reset gates both grants so a write in flight is dropped at once
  always_comb begin
    gnt1 = 1'b0;
    gnt0 = 1'b0;
    if (!reset) begin
      gnt1 = m1_req & (~m0_req | (wait_cnt == WAIT_LIMIT));
      gnt0 = m0_req & ~gnt1;
    end
  end

  // Route the granted port to the memory and return read data to it
  always_comb begin
    m0_ack    = gnt0;
    m1_ack    = gnt1;
    mem_read  = (gnt0 & ~m0_we) | (gnt1 & ~m1_we);
    mem_write = (gnt0 & m0_we) | (gnt1 & m1_we);
    mem_addr  = '0;
    mem_wdata = '0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    if (gnt0) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      if (!m0_we) m0_rdata = mem_rdata;
    end else if (gnt1) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      if (!m1_we) m1_rdata = mem_rdata;
    end
  end

  // Age port 1 while it is being denied; any grant or withdrawn request resets the age
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!m1_req || gnt1) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Count contention cycles, saturating at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (m0_req && m1_req && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: stimulus pushes expected grants into a queue,
// a monitor pops one entry per observed ack and compares the memory side.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } grant_t;

  grant_t sb[$];

  logic [31:0] mem [0:255];
  logic        preload;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write at the rising edge
  assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;
  always @(posedge clk) begin
    if (preload) mem[8] <= 32'h11111111;
    else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void expect_grant(input logic p, input logic we, input logic [31:0] a,
                                       input logic [31:0] d, input logic [31:0] r);
    grant_t g;
    g.port = p; g.we = we; g.addr = a; g.wdata = d; g.rdata = r;
    sb.push_back(g);
  endfunction

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every ack consumes one expected grant
  initial begin
    grant_t g;
    forever begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        if (m0_ack && m1_ack) begin
          chk("dual_ack", 32'd1, 32'd0);
        end else if (sb.size() == 0) begin
          chk("unexpected_ack_port", {31'd0, m1_ack}, 32'hFFFFFFFF);
        end else begin
          g = sb.pop_front();
          chk("grant_port", {31'd0, m1_ack}, {31'd0, g.port});
          chk("mem_write", {31'd0, mem_write}, {31'd0, g.we});
          chk("mem_read", {31'd0, mem_read}, {31'd0, ~g.we});
          chk("mem_addr", mem_addr, g.addr);
          chk("mem_wdata", mem_wdata, g.wdata);
          chk("granted_rdata", g.port ? m1_rdata : m0_rdata, g.rdata);
          chk("other_rdata", g.port ? m0_rdata : m1_rdata, 32'h0);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; preload = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    @(posedge clk); #1;
    preload = 1'b0;
    // Requests during reset must not be granted
    m0_req = 1; m1_req = 1; m1_we = 1;
    #2;
    chk("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
    chk("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    @(posedge clk); #1;
    chk("rst_conflict", {16'd0, conflict_cnt}, 32'd0);
    m0_req = 0; m1_req = 0; m1_we = 0;
    #2 reset = 1'b0;
    #1;
    chk("post_rst_mem_addr", mem_addr, 32'd0);
    chk("post_rst_conflict", {16'd0, conflict_cnt}, 32'd0);
    @(posedge clk); #1;

    // Single master: write then read back
    expect_grant(0, 1, 32'h10, 32'h12345678, 32'h0);
    drive(1, 1, 32'h10, 32'h12345678, 0, 0, 0, 0);
    expect_grant(0, 0, 32'h10, 32'h0, 32'h12345678);
    drive(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);

    // Idle CPU: port 1 served the same cycle
    expect_grant(1, 0, 32'h10, 32'h0, 32'h12345678);
    drive(0, 0, 0, 0, 1, 0, 32'h10, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_conflict", {16'd0, conflict_cnt}, 32'd0);

    // Sustained contention: 0,0,0,0,1,0,0,0,0,1,0,0
    for (int i = 0; i < 12; i++) begin
      if (i == 4 || i == 9) expect_grant(1, 1, 32'h30, 32'hA5A5A5A5, 32'h0);
      else                  expect_grant(0, 0, 32'h10, 32'h0, 32'h12345678);
      drive(1, 0, 32'h10, 32'h0, 1, 1, 32'h30, 32'hA5A5A5A5);
    end
    chk("contention_conflict", {16'd0, conflict_cnt}, 32'd12);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Aging loss: 3 waits, drop, then 4 fresh denials before grant
    for (int i = 0; i < 3; i++) begin
      expect_grant(0, 0, 32'h10, 32'h0, 32'h12345678);
      drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h10, 32'h0);
    end
    expect_grant(0, 0, 32'h10, 32'h0, 32'h12345678);
    drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h10, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) expect_grant(1, 0, 32'h10, 32'h0, 32'h12345678);
      else        expect_grant(0, 0, 32'h10, 32'h0, 32'h12345678);
      drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h10, 32'h0);
    end
    chk("aging_conflict", {16'd0, conflict_cnt}, 32'd20);

    // Port 0 write followed by port 1 read of the same address
    expect_grant(0, 1, 32'h40, 32'hCAFEF00D, 32'h0);
    drive(1, 1, 32'h40, 32'hCAFEF00D, 0, 0, 0, 0);
    expect_grant(1, 0, 32'h40, 32'h0, 32'hCAFEF00D);
    drive(0, 0, 0, 0, 1, 0, 32'h40, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset asserted in the middle of a granted port 1 write
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hDEADBEEF;
    #1;
    chk("pre_rst_mem_write", {31'd0, mem_write}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("mid_rst_m1_ack", {31'd0, m1_ack}, 32'd0);
    chk("mid_rst_conflict", {16'd0, conflict_cnt}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_mem_unchanged", mem[8], 32'h11111111);
    m1_req = 0; m1_we = 0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Saturation of the contention counter
    for (int i = 0; i < 70000; i++) begin
      if (i % 5 == 4) expect_grant(1, 0, 32'h40, 32'h5555, 32'hCAFEF00D);
      else            expect_grant(0, 0, 32'h10, 32'h0, 32'h12345678);
      drive(1, 0, 32'h10, 32'h0, 1, 0, 32'h40, 32'h5555);
      if (i == 65533) chk("sat_below", {16'd0, conflict_cnt}, 32'h0000FFFE);
      if (i == 65534) chk("sat_reach", {16'd0, conflict_cnt}, 32'h0000FFFF);
    end
    chk("sat_hold", {16'd0, conflict_cnt}, 32'h0000FFFF);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory between the CPU pipeline MEM stage (port 0) and a secondary master such as a loader or DMA engine (port 1). It grants at most one access per cycle: CPU by default, with an aging counter that forces a grant to port 1 after a bounded wait. Each access completes in one cycle (combinational read, write on the next rising edge), and the unit keeps a saturating contention counter for debug. It sits between the pipeline/peripheral masters and the data memory.

## Interface
- ADDR_W, 32, address width (byte address, passed through unchanged)
- DATA_W, 32, data width
- MAX_WAIT, 4, number of consecutive denied cycles after which port 1 wins over port 0; legal range 1..15
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- m0_req  in  1  CPU access request (level, held until acked)
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  CPU byte address
- m0_wdata  in  DATA_W  CPU write data
- m0_ack  out  1  CPU access performed this cycle
- m0_rdata  out  DATA_W  read data to CPU
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as port 0, for the secondary master
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (combinational, 0 when mem_read=0)
- conflict_cnt  out  16  saturating count of cycles with m0_req=1 and m1_req=1

## Operation
- State: wait_cnt (4 bits), conflict_cnt (16 bits). No other state.
- Grant, combinational from current inputs and wait_cnt:
  - gnt1 = m1_req & (~m0_req | wait_cnt == MAX_WAIT)
  - gnt0 = m0_req & ~gnt1
  - While reset=1, both grants are forced to 0.
- Outputs:
  - m0_ack = gnt0; m1_ack = gnt1.
  - mem_read = (gnt0 & ~m0_we) | (gnt1 & ~m1_we).
  - mem_write = (gnt0 & m0_we) | (gnt1 & m1_we).
  - mem_addr and mem_wdata come from the granted port, and are 0 when neither port is granted.
  - m0_rdata = mem_rdata when gnt0 & ~m0_we, else 0. m1_rdata is the same rule using gnt1 and m1_we.
- wait_cnt, updated on the clock edge:
  - cleared if m1_req=0 or gnt1=1;
  - else incremented, saturating at MAX_WAIT.
  - Result: port 1 waits at most MAX_WAIT cycles under continuous CPU traffic, then receives exactly one access before the CPU regains priority.
- conflict_cnt: +1 per cycle with m0_req & m1_req; holds at 16'hFFFF.
- A denied port must hold req/we/addr/wdata stable until it sees ack. The CPU stall condition is m0_req & ~m0_ack.

## Timing
- Reset values: wait_cnt=0, conflict_cnt=0. All outputs are 0 while reset is high and immediately after it deasserts.
- Access latency is zero cycles to ack. Read data is valid in the same cycle as ack. A write commits at the rising edge that ends the ack cycle.
- Throughput is one access per cycle total. Back-to-back grants to the same port are allowed with no bubble.
- Simultaneous requests with wait_cnt < MAX_WAIT: port 0 wins and wait_cnt increments.
- Simultaneous requests with wait_cnt == MAX_WAIT: port 1 wins and wait_cnt returns to 0 next cycle.
- m1_req dropping while waiting: wait_cnt clears, and the accumulated age is lost.
- Reset asserted mid-access: mem_write drops asynchronously, so no write commits on that edge; both counters clear.
- Same-address write by port 0 and read by port 1 in consecutive cycles: the read returns the new data, because the write committed at the intervening edge.

## Test plan
- Single masters:
  - Stimulus: port 0 only, write 0x12345678 to addr 0x10, then read addr 0x10.
  - Required: m0_ack=1 both cycles, mem_write then mem_read, m0_rdata=0x12345678, m1_ack=0 throughout.
- Sustained contention, MAX_WAIT=4:
  - Stimulus: m0_req and m1_req both held high for 12 cycles.
  - Required grant sequence 0,0,0,0,1,0,0,0,0,1,0,0; conflict_cnt=12 afterward.
- Idle CPU:
  - Stimulus: m1_req high with m0_req low.
  - Required: m1_ack the same cycle, wait_cnt stays 0.
- Aging loss:
  - Stimulus: m1 waits 3 cycles, drops req for 1 cycle, re-requests under CPU load.
  - Required: port 1 is granted only after 4 further denied cycles.
- Reset mid-write:
  - Stimulus: assert reset asynchronously during a granted m1 write to addr 0x20.
  - Required: mem_write falls immediately, the memory location is unchanged, both counters read 0.
- Saturation:
  - Stimulus: force 70000 conflict cycles.
  - Required: conflict_cnt=16'hFFFF and it holds there.
